// File: rtl/gray_disp_scanner.sv
// gray_disp_scanner: four-digit time-multiplexed scan controller for the shared
// Gray-code/BCD 7-segment decoder. It holds four digit codes and cycles them onto
// the decoder X input, with active-low one-hot digit strobes. It also sequences
// lamp test (at power-on and on request), display enable and leading-zero
// blanking through the decoder n_t/n_m controls.
//
// Every output is registered from the next-cycle values of the slot select, the
// FSM state and the digit registers. As a result, an_n, dig_x, n_t and n_m all
// change on the same edge as the state that produces them.
//
// Handshake: there is no valid/ready pair. A write is a single-cycle strobe,
// where wr_en=1 commits wr_data to digit[wr_addr] on that rising edge. lt_req is
// likewise a single-cycle request that is sampled on the edge.

module gray_disp_scanner #(
    parameter int DIV       = 1000,
    parameter int LT_FRAMES = 2,
    parameter int LZB       = 1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       disp_en,
    input  logic       lt_req,
    output logic [3:0] dig_x,
    output logic       n_t,
    output logic       n_m,
    output logic [3:0] an_n,
    output logic       frame_tick,
    output logic       lt_busy,
    output logic [1:0] fsm_state
);

    localparam int LT_TOTAL = LT_FRAMES * 4 * DIV;
    localparam int PW       = $clog2(DIV);
    localparam int LW       = $clog2(LT_TOTAL);

    typedef enum logic [1:0] {
        ST_LAMP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [1:0]    sel, sel_nxt;
    logic [LW-1:0] lt_cnt, lt_cnt_nxt;
    logic [3:0]    digit   [4];
    logic [3:0]    dig_nxt [4];
    logic [3:0]    nz_above;
    logic          slot_tick;
    logic          lz_blank;

    assign fsm_state = state;
    assign slot_tick = (presc == PW'(DIV - 1));

    // Next-cycle scan position: the prescaler wraps every DIV cycles and advances sel
    always_comb begin
        presc_nxt = slot_tick ? '0 : presc + 1'b1;
        sel_nxt   = slot_tick ? sel + 2'd1 : sel;
    end

    // Next-cycle digit registers, so a write is visible on dig_x the following cycle
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            dig_nxt[i] = digit[i];
        end
        if (wr_en) begin
            dig_nxt[wr_addr] = wr_data;
        end
    end

    // nz_above[i] is set when digit i or any higher digit is non-zero
    always_comb begin
        logic acc;
        acc      = 1'b0;
        nz_above = '0;
        for (int i = 3; i >= 0; i--) begin
            acc         = acc | (dig_nxt[i] != 4'd0);
            nz_above[i] = acc;
        end
        lz_blank = (LZB != 0) && (sel_nxt != 2'd0) && !nz_above[sel_nxt];
    end

    // Mode sequencing: a lamp-test request wins over everything, including disp_en
    always_comb begin
        state_nxt  = state;
        lt_cnt_nxt = lt_cnt;
        if (lt_req) begin
            state_nxt  = ST_LAMP;
            lt_cnt_nxt = LW'(LT_TOTAL - 1);
        end else begin
            case (state)
                ST_LAMP: begin
                    if (lt_cnt == '0) begin
                        state_nxt = disp_en ? ST_RUN : ST_BLANK;
                    end else begin
                        lt_cnt_nxt = lt_cnt - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!disp_en) state_nxt = ST_BLANK;
                end
                ST_BLANK: begin
                    if (disp_en) state_nxt = ST_RUN;
                end
                default: state_nxt = ST_LAMP;
            endcase
        end
    end

    // State and registered outputs, all derived from the next-cycle values
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_LAMP;
            lt_cnt     <= LW'(LT_TOTAL - 1);
            presc      <= '0;
            sel        <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                digit[i] <= 4'd0;
            end
            dig_x      <= 4'd0;
            n_t        <= 1'b0;
            n_m        <= 1'b1;
            an_n       <= 4'b1110;
            frame_tick <= 1'b0;
            lt_busy    <= 1'b1;
        end else begin
            state      <= state_nxt;
            lt_cnt     <= lt_cnt_nxt;
            presc      <= presc_nxt;
            sel        <= sel_nxt;
            for (int i = 0; i < 4; i++) begin
                digit[i] <= dig_nxt[i];
            end
            dig_x      <= dig_nxt[sel_nxt];
            an_n       <= ~(4'b0001 << sel_nxt);
            frame_tick <= slot_tick && (sel == 2'd3);
            lt_busy    <= (state_nxt == ST_LAMP);
            case (state_nxt)
                ST_LAMP: begin
                    n_t <= 1'b0;
                    n_m <= 1'b1;
                end
                ST_RUN: begin
                    n_t <= 1'b1;
                    n_m <= !lz_blank;
                end
                default: begin
                    n_t <= 1'b1;
                    n_m <= 1'b0;
                end
            endcase
        end
    end

endmodule
